// File: rtl/ap_pkg.sv
// Shared types and constants for the AP DMA burst engine.
package ap_pkg;

    localparam logic [1:0] OP_READ       = 2'b01;
    localparam logic [1:0] OP_WRITE      = 2'b10;
    localparam logic [1:0] AXI_OKAY      = 2'b00;
    localparam int         MAX_BURST_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } state_e;

    // A command is executable only with a known opcode and a burst of 1..max_burst beats.
    function automatic logic cmd_legal(input logic [1:0] op, input logic [7:0] burst,
                                       input int max_burst);
        return ((op == OP_READ) || (op == OP_WRITE)) && (burst != 8'd0) &&
               (int'(burst) <= max_burst);
    endfunction

endpackage

// File: rtl/dma_beat_counter.sv
// Beat counter shared by the read and write data phases; last flags the final beat.
module dma_beat_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] length,
    input  logic       inc,
    output logic [7:0] count,
    output logic       last
);

    logic [7:0] count_q;

    // Load clears for a new command; each accepted beat advances the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else if (load) begin
            count_q <= 8'd0;
        end else if (inc) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign count = count_q;
    assign last  = (count_q == length);

endmodule

// File: rtl/dma_burst_engine.sv
// Single-command AXI4 burst engine: reads fill the inbound DMA FIFO, writes drain the outbound one.
module dma_burst_engine
    import ap_pkg::*;
#(
    parameter int ADDR      = 32,
    parameter int BITLEN    = 64,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    // command
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR-1:0]   cmd_addr,
    input  logic [7:0]        cmd_burst,
    // AXI read address
    output logic [ADDR-1:0]   araddr,
    output logic [7:0]        arlen,
    output logic              arvalid,
    input  logic              arready,
    // AXI read data
    input  logic [BITLEN-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // AXI write address
    output logic [ADDR-1:0]   awaddr,
    output logic [7:0]        awlen,
    output logic              awvalid,
    input  logic              awready,
    // AXI write data
    output logic [BITLEN-1:0] wdata,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    // AXI write response
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    // inbound DMA FIFO
    output logic [BITLEN-1:0] rd_fifo_din,
    output logic              rd_fifo_wr_en,
    input  logic              rd_fifo_full,
    // outbound DMA FIFO (first-word-fall-through)
    input  logic [BITLEN-1:0] wr_fifo_dout,
    output logic              wr_fifo_rd_en,
    input  logic              wr_fifo_empty,
    // status
    output logic              done,
    output logic              err
);

    localparam logic [ADDR-1:0] ALIGN_MASK = ~{{(ADDR-3){1'b0}}, 3'b111};

    state_e          state_q, state_d;
    logic [ADDR-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [7:0]      arlen_q, arlen_d, awlen_q, awlen_d;
    logic [7:0]      len_q, len_d;
    logic            arvalid_q, arvalid_d, awvalid_q, awvalid_d;
    logic            errf_q, errf_d;
    logic            done_q, done_d, err_q, err_d;

    logic            cnt_load, cnt_inc, cnt_last;
    logic [7:0]      cnt;
    logic            beat_err;
    logic [ADDR-1:0] addr_al;
    logic [7:0]      burst_m1;

    assign addr_al  = cmd_addr & ALIGN_MASK;
    assign burst_m1 = cmd_burst - 8'd1;

    dma_beat_counter u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_load),
        .length (len_q),
        .inc    (cnt_inc),
        .count  (cnt),
        .last   (cnt_last)
    );

    // Next-state and handshake decode; bus-side strobes are state-gated combinational.
    always_comb begin
        state_d       = state_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        awaddr_d      = awaddr_q;
        awlen_d       = awlen_q;
        len_d         = len_q;
        arvalid_d     = arvalid_q;
        awvalid_d     = awvalid_q;
        errf_d        = errf_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        cnt_load      = 1'b0;
        cnt_inc       = 1'b0;
        beat_err      = 1'b0;
        cmd_ready     = 1'b0;
        rready        = 1'b0;
        rd_fifo_wr_en = 1'b0;
        wvalid        = 1'b0;
        wlast         = 1'b0;
        wr_fifo_rd_en = 1'b0;
        bready        = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cnt_load = 1'b1;
                    errf_d   = 1'b0;
                    if (!cmd_legal(cmd_op, cmd_burst, MAX_BURST)) begin
                        // Swallowed without touching the bus; failure reported next cycle.
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        len_d = burst_m1;
                        if (cmd_op == OP_READ) begin
                            araddr_d  = addr_al;
                            arlen_d   = burst_m1;
                            arvalid_d = 1'b1;
                            state_d   = RD_ADDR;
                        end else begin
                            awaddr_d  = addr_al;
                            awlen_d   = burst_m1;
                            awvalid_d = 1'b1;
                            state_d   = WR_ADDR;
                        end
                    end
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                rready = ~rd_fifo_full;
                if (rvalid && rready) begin
                    rd_fifo_wr_en = 1'b1;
                    cnt_inc       = 1'b1;
                    // Bad response, rlast before the final beat, or no rlast on it.
                    beat_err = (rresp != AXI_OKAY) ||
                               (rlast && (cnt < len_q)) ||
                               (cnt_last && !rlast);
                    if (rlast || cnt_last) begin
                        done_d  = 1'b1;
                        err_d   = errf_q | beat_err;
                        errf_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        errf_d = errf_q | beat_err;
                    end
                end
            end
            WR_ADDR: begin
                if (awready) begin
                    awvalid_d = 1'b0;
                    state_d   = WR_DATA;
                end
            end
            WR_DATA: begin
                wvalid = ~wr_fifo_empty;
                wlast  = cnt_last;
                if (wvalid && wready) begin
                    wr_fifo_rd_en = 1'b1;
                    cnt_inc       = 1'b1;
                    if (cnt_last) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    done_d  = 1'b1;
                    err_d   = errf_q | (bresp != AXI_OKAY);
                    errf_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            araddr_q  <= '0;
            arlen_q   <= 8'd0;
            awaddr_q  <= '0;
            awlen_q   <= 8'd0;
            len_q     <= 8'd0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            errf_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            len_q     <= len_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            errf_q    <= errf_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign araddr      = araddr_q;
    assign arlen       = arlen_q;
    assign arvalid     = arvalid_q;
    assign awaddr      = awaddr_q;
    assign awlen       = awlen_q;
    assign awvalid     = awvalid_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rd_fifo_din = rdata;
    assign wdata       = wr_fifo_dout;

endmodule

// File: tb/tb_dma_burst_engine.sv
// Scoreboard bench for dma_burst_engine: stimulus queues expectations, a negedge monitor checks them.
module tb_dma_burst_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_burst = '0;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic        arvalid, awvalid, arready = 1'b0, awready = 1'b0;
    logic [63:0] rdata = '0;
    logic [1:0]  rresp = 2'b00, bresp = 2'b00;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;
    logic [63:0] wdata;
    logic        wlast, wvalid, wready = 1'b0;
    logic        bvalid = 1'b0, bready;
    logic [63:0] rd_fifo_din;
    logic        rd_fifo_wr_en, rd_fifo_full = 1'b0;
    logic [63:0] wr_fifo_dout = '0;
    logic        wr_fifo_rd_en, wr_fifo_empty = 1'b1;
    logic        done, err;

    int checks = 0;
    int errors = 0;
    int fifo_wr_cnt = 0;

    logic [39:0] exp_ar[$];
    logic [39:0] exp_aw[$];
    logic [63:0] exp_fifo[$];
    logic [64:0] exp_w[$];
    logic        exp_done[$];
    logic [63:0] wq[$];

    always #5 clk = ~clk;

    dma_burst_engine dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .rd_fifo_din(rd_fifo_din), .rd_fifo_wr_en(rd_fifo_wr_en), .rd_fifo_full(rd_fifo_full),
        .wr_fifo_dout(wr_fifo_dout), .wr_fifo_rd_en(wr_fifo_rd_en), .wr_fifo_empty(wr_fifo_empty),
        .done(done), .err(err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT-presented transfer is matched against the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
                else chk("ar_addr_len", {araddr, arlen}, exp_ar.pop_front());
            end
            if (awvalid && awready) begin
                if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
                else chk("aw_addr_len", {awaddr, awlen}, exp_aw.pop_front());
            end
            if (rd_fifo_wr_en) begin
                fifo_wr_cnt++;
                if (exp_fifo.size() == 0) chk("fifo_wr_unexpected", 1, 0);
                else chk("fifo_din", rd_fifo_din, exp_fifo.pop_front());
            end
            if (wvalid && wready) begin
                if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
                else chk("w_last_data", {wlast, wdata}, exp_w.pop_front());
            end
            if (done) begin
                if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_err", err, exp_done.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] a, input logic [7:0] b);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_burst = b;
        #1 chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_ar();
        int n = 0;
        arready = 1'b1;
        while (!arvalid && n < 20) begin tick(); n++; end
        if (n >= 20) chk("ar_timeout", 1, 0);
        tick();
        arready = 1'b0;
        chk("arvalid_drop", arvalid, 0);
    endtask

    task automatic do_aw();
        int n = 0;
        awready = 1'b1;
        while (!awvalid && n < 20) begin tick(); n++; end
        if (n >= 20) chk("aw_timeout", 1, 0);
        tick();
        awready = 1'b0;
        chk("awvalid_drop", awvalid, 0);
    endtask

    task automatic rd_beat(input logic [63:0] d, input logic l, input logic [1:0] rs);
        int n = 0;
        rvalid = 1'b1; rdata = d; rlast = l; rresp = rs;
        #1;
        while (!rready && n < 50) begin @(posedge clk); #2; n++; end
        if (n >= 50) chk("rready_timeout", 1, 0);
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    task automatic wr_data(input int nb, input bit toggle);
        int sent = 0;
        int cyc = 0;
        logic hs;
        while (sent < nb && cyc < 200) begin
            wr_fifo_empty = (wq.size() == 0);
            wr_fifo_dout  = (wq.size() == 0) ? 64'd0 : wq[0];
            wready        = toggle ? cyc[0] : 1'b1;
            #1 hs = wvalid && wready;
            @(posedge clk); #1;
            if (hs) begin void'(wq.pop_front()); sent++; end
            cyc++;
        end
        if (cyc >= 200) chk("w_timeout", 1, 0);
        wready = 1'b0;
        wr_fifo_empty = (wq.size() == 0);
        wr_fifo_dout  = (wq.size() == 0) ? 64'd0 : wq[0];
    endtask

    task automatic do_b(input logic [1:0] rs);
        int n = 0;
        bvalid = 1'b1; bresp = rs;
        #1;
        while (!bready && n < 50) begin @(posedge clk); #2; n++; end
        if (n >= 50) chk("bready_timeout", 1, 0);
        @(posedge clk); #1;
        bvalid = 1'b0; bresp = 2'b00;
    endtask

    task automatic retire_chk(input string name);
        chk({name, "_done"}, done, 1);
        chk({name, "_cmd_ready"}, cmd_ready, 1);
        tick();
        chk({name, "_done_pulse"}, done, 0);
    endtask

    task automatic illegal(input logic [1:0] op, input logic [7:0] b);
        exp_done.push_back(1'b1);
        send_cmd(op, 32'h0000_1000, b);
        chk("illegal_done", done, 1);
        chk("illegal_err", err, 1);
        chk("illegal_noar", arvalid, 0);
        chk("illegal_noaw", awvalid, 0);
        tick();
        chk("illegal_pulse", done, 0);
        chk("illegal_noar2", arvalid | awvalid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_araddr_arlen", {araddr, arlen}, 0);
        chk("rst_awaddr_awlen", {awaddr, awlen}, 0);
        chk("rst_strobes", {wvalid, rready, bready, rd_fifo_wr_en, wr_fifo_rd_en}, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rst_n = 1'b1;
        tick();

        // Read, 8 beats, unaligned base address
        exp_ar.push_back({32'h1000_0000, 8'd7});
        for (int i = 0; i < 8; i++) exp_fifo.push_back(64'hA000_0000_0000_0000 + 64'(i));
        exp_done.push_back(1'b0);
        send_cmd(2'b01, 32'h1000_0004, 8'd8);
        chk("rd_arvalid_latency", arvalid, 1);
        chk("rd_cmd_ready_busy", cmd_ready, 0);
        do_ar();
        for (int i = 0; i < 8; i++) rd_beat(64'hA000_0000_0000_0000 + 64'(i), i == 7, 2'b00);
        retire_chk("rd8");

        // Write, 16 beats, wready toggling, FIFO starts empty
        exp_aw.push_back({32'h3000_0008, 8'd15});
        for (int i = 0; i < 16; i++) exp_w.push_back({i == 15, 64'hB000_0000_0000_0000 + 64'(i)});
        exp_done.push_back(1'b0);
        send_cmd(2'b10, 32'h3000_000F, 8'd16);
        chk("wr_awvalid_latency", awvalid, 1);
        do_aw();
        wr_fifo_empty = 1'b1; wready = 1'b1;
        #1 chk("wr_empty_stall", wvalid, 0);
        tick();
        wready = 1'b0;
        for (int i = 0; i < 16; i++) wq.push_back(64'hB000_0000_0000_0000 + 64'(i));
        wr_data(16, 1'b1);
        do_b(2'b00);
        retire_chk("wr16");

        // Read with FIFO back-pressure for 3 cycles mid-burst
        fifo_wr_cnt = 0;
        exp_ar.push_back({32'h2000_0000, 8'd5});
        for (int i = 0; i < 6; i++) exp_fifo.push_back(64'hC000_0000_0000_0000 + 64'(i));
        exp_done.push_back(1'b0);
        send_cmd(2'b01, 32'h2000_0000, 8'd6);
        do_ar();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                rvalid = 1'b1; rdata = 64'hC000_0000_0000_0003; rd_fifo_full = 1'b1;
                repeat (3) begin
                    #1 chk("bp_rready_low", rready, 0);
                    chk("bp_no_fifo_wr", rd_fifo_wr_en, 0);
                    @(posedge clk); #1;
                end
                rd_fifo_full = 1'b0;
            end
            rd_beat(64'hC000_0000_0000_0000 + 64'(i), i == 5, 2'b00);
        end
        retire_chk("bp");
        chk("bp_total_writes", fifo_wr_cnt, 6);

        // Illegal commands
        illegal(2'b11, 8'd4);
        illegal(2'b01, 8'd0);
        illegal(2'b10, 8'd17);
        illegal(2'b00, 8'd1);

        // Early rlast on beat 2 of 4
        exp_ar.push_back({32'h4000_0000, 8'd3});
        exp_fifo.push_back(64'hD0); exp_fifo.push_back(64'hD1);
        exp_done.push_back(1'b1);
        send_cmd(2'b01, 32'h4000_0000, 8'd4);
        do_ar();
        rd_beat(64'hD0, 1'b0, 2'b00);
        rd_beat(64'hD1, 1'b1, 2'b00);
        chk("early_rlast_err", err, 1);
        retire_chk("early_rlast");
        chk("early_rlast_idle", rready, 0);

        // Single-beat read with SLVERR response
        exp_ar.push_back({32'h5000_0000, 8'd0});
        exp_fifo.push_back(64'hE0);
        exp_done.push_back(1'b1);
        send_cmd(2'b01, 32'h5000_0007, 8'd1);
        do_ar();
        rd_beat(64'hE0, 1'b1, 2'b10);
        retire_chk("rresp_err");

        // Reset in the middle of a write data phase
        exp_aw.push_back({32'h6000_0000, 8'd3});
        exp_w.push_back({1'b0, 64'hF0}); exp_w.push_back({1'b0, 64'hF1});
        for (int i = 0; i < 4; i++) wq.push_back(64'hF0 + 64'(i));
        send_cmd(2'b10, 32'h6000_0000, 8'd4);
        do_aw();
        wr_data(2, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("midrst_wvalid", wvalid, 0);
        chk("midrst_valids", {arvalid, awvalid, bready, rready}, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_done", done, 0);
        wq.delete();
        wr_fifo_empty = 1'b1;
        rst_n = 1'b1;
        tick();

        // Normal command after reset
        exp_ar.push_back({32'h7000_0018, 8'd1});
        exp_fifo.push_back(64'h77); exp_fifo.push_back(64'h78);
        exp_done.push_back(1'b0);
        send_cmd(2'b01, 32'h7000_001C, 8'd2);
        do_ar();
        rd_beat(64'h77, 1'b0, 2'b00);
        rd_beat(64'h78, 1'b1, 2'b00);
        retire_chk("post_rst");

        tick(); tick();
        chk("leftover_ar", exp_ar.size(), 0);
        chk("leftover_aw", exp_aw.size(), 0);
        chk("leftover_fifo", exp_fifo.size(), 0);
        chk("leftover_w", exp_w.size(), 0);
        chk("leftover_done", exp_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
